// File: rtl/mem_resp_pkg.sv
// Shared constants and byte-lane helpers for the mem_responder memory slice.
package mem_resp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_e;

    function automatic logic [3:0] lane_strobe(input logic [1:0] lane, input logic byte_en);
        logic [3:0] strobe;
        if (byte_en) begin
            strobe = 4'b0001 << lane;
        end else begin
            strobe = 4'b1111;
        end
        return strobe;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // Byte writes replicate the low byte so any enabled lane sees it.
    function automatic logic [31:0] lane_wdata(input logic [31:0] wdata, input logic byte_en);
        logic [31:0] d;
        if (byte_en) begin
            d = {4{wdata[7:0]}};
        end else begin
            d = wdata;
        end
        return d;
    endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Word array with synchronous byte-lane writes and combinational read.
module mem_resp_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    lane_en,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Lane-masked write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_en[l]) begin
                    mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Wait-stated memory responder: IDLE/WAIT/RESP FSM in front of mem_resp_ram.
// Optional range/alignment checking is enabled by defining MEM_RESP_ERR_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(WAIT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             be_q, be_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_s;
    logic             ram_we_s;
    logic [31:0]      ram_rdata_s;

    // State, counter and request capture registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            we_q    <= 1'b0;
            be_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; inputs are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    be_d    = byte_en;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MEM_RESP_ERR_EN
    assign err_s = (addr_q[31:2] >= 30'(DEPTH_WORDS)) || (!be_q && (addr_q[1:0] != 2'd0));
`else
    logic unused_addr_s;
    assign unused_addr_s = ^addr_q[31:2+AW];
    assign err_s         = 1'b0;
`endif

    // Reset gates the commit so an aborted access never reaches the RAM.
    assign ram_we_s = (state_q == S_RESP) && we_q && !err_s && reset;

    mem_resp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we_s),
        .lane_en(lane_strobe(addr_q[1:0], be_q)),
        .idx    (addr_q[2 +: AW]),
        .wdata  (lane_wdata(wdata_q, be_q)),
        .rdata  (ram_rdata_s)
    );

    // Response outputs decode directly from the state register.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        err   = 1'b0;
        rdata = 32'd0;
        if (state_q == S_RESP) begin
            ready = 1'b1;
            busy  = 1'b1;
            err   = err_s;
            if (!we_q && !err_s) begin
                if (be_q) begin
                    rdata = {24'd0, lane_byte(ram_rdata_s, addr_q[1:0])};
                end else begin
                    rdata = ram_rdata_s;
                end
            end else begin
                rdata = 32'd0;
            end
        end else begin
            busy = (state_q != S_IDLE);
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle ARM controller's load/store/fetch traffic. It accepts one request at a time over a req/ready handshake and runs a programmable wait-state counter. It then completes a word or byte read or write against an internal RAM and returns data with a single-cycle `ready` pulse. It sits between the controller/datapath address mux and storage, replacing the zero-latency combinational memory.

## Interface
- `DEPTH_WORDS`, default 64: RAM depth in 32-bit words; power of two.
- `WAIT_CYCLES`, default 2: wait states between accept and response; 0..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on rising `clk`).
- `req`  in  1  request valid; sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read.
- `byte_en`  in  1  1 = byte access (LDRB/STRB), 0 = word access.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data; byte writes use `wdata[7:0]`.
- `ready`  out  1  one-cycle completion pulse.
- `rdata`  out  32  read data, valid while `ready`=1.
- `err`  out  1  access error, valid while `ready`=1.
- `busy`  out  1  1 from accept until the response cycle inclusive.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if `req`=1, capture `we`, `byte_en`, `addr`, `wdata` and set `busy`=1. Go to WAIT with counter=`WAIT_CYCLES`-1, or go directly to RESP if `WAIT_CYCLES`=0.
- WAIT: decrement the counter each cycle. Go to RESP when the counter is 0. Input changes are ignored; only the captured values are used.
- RESP: drive `ready`=1 for exactly one cycle, then always return to IDLE. `req` is ignored in RESP, so the requester drops `req` on seeing `ready`. A `req` still high in the following IDLE cycle starts a new access.
- Word index = `addr[31:2]` modulo `DEPTH_WORDS`. Lane = `addr[1:0]`, little-endian.
- Word read: `rdata` = mem[index].
- Byte read: `rdata` = {24'b0, selected lane}.
- Word write: mem[index] = `wdata`.
- Byte write: only the selected lane is updated from `wdata[7:0]`; the other lanes are unchanged.
- Writes commit on the clock edge that ends the RESP cycle. `rdata` is 0 for writes.
- Outside RESP, `rdata`=0 and `err`=0.
- Reset: state=IDLE, `ready`=0, `busy`=0, `rdata`=0, `err`=0, counter=0. RAM contents are not cleared.
- Reset mid-operation aborts the access: a pending write is never committed and no `ready` is issued.

## Timing
- Accept at edge t (IDLE, `req`=1) gives `ready`=1 in cycle t+`WAIT_CYCLES`+1. Total latency is `WAIT_CYCLES`+1 cycles.
- Throughput is one access per `WAIT_CYCLES`+2 cycles, because of the mandatory IDLE cycle.
- `busy` rises the cycle after accept and falls the cycle after RESP.
- `ready` never stays high for two consecutive cycles.
- A read in RESP sees all writes committed earlier, including a write that finished immediately before.

## Configuration
- `MEM_RESP_ERR_EN` defined: error checking is enabled.
  - `err`=1 with `ready` if `addr[31:2]` ≥ `DEPTH_WORDS`, or if a word access has `addr[1:0]`≠0.
  - On error: no write, `rdata`=0, normal latency.
- Not defined: `err` is tied 0, out-of-range addresses wrap modulo depth, and `addr[1:0]` is ignored for word accesses.

## Structure
- Package `mem_resp_pkg` holds:
  - the state encoding localparams (IDLE=0, WAIT=1, RESP=2);
  - the counter width constant (4);
  - lane-select helpers.
- Sub-module `mem_resp_ram`: synchronous-write, combinational-read word array with four byte-lane write enables.
- The top level holds the FSM, capture registers and counter.

## Test plan
- Reset low for 2 cycles, then high → `ready`=0, `busy`=0, `rdata`=0, `err`=0; FSM in IDLE.
- `WAIT_CYCLES`=2: word write 0xDEADBEEF to 0x10, then word read 0x10 → each `ready` arrives 3 cycles after accept; `rdata`=0xDEADBEEF.
- Byte write 0x55 to 0x11 over 0xDEADBEEF, then word read 0x10 → 0xDEAD55EF. Byte read 0x13 → 0x000000DE.
- `WAIT_CYCLES`=0, `req` held high continuously → `ready` on alternating cycles, never back-to-back.
- Write accepted, then reset low during WAIT → no `ready`; a later read of the same address returns the old value.
- `MEM_RESP_ERR_EN`, `DEPTH_WORDS`=64: word read 0x102 → `err`=1, `rdata`=0. Write 0x100 → `err`=1 with no RAM change. Without the macro, write 0x100 lands in word 0.
